// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_if
//  Description : Byte-side interface of the UART receiver. Carries the FIFO
//                read handshake and the per-frame status pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rd_en;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_empty;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  // Receiver side: supplies bytes and status, accepts pops
  modport master (
    input  rd_en,
    output rx_data,
    output rx_empty,
    output parity_err,
    output frame_err,
    output overrun
  );

  // Consumer side: pops bytes and observes status
  modport slave (
    output rd_en,
    input  rx_data,
    input  rx_empty,
    input  parity_err,
    input  frame_err,
    input  overrun
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : UART receiver. Synchronizes and 16x oversamples the serial
//                line, deframes start/data/parity/stop, and queues bytes in a
//                first-word-fall-through FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int SYS_CLK_FREQ   = 50000000,
  parameter int BAUD_RATE      = 19200,
  parameter int DATA_BITS      = 8,
  parameter int STOP_BITS      = 1,
  parameter int PARITY_MODE    = 1,
  parameter int FIFO_ADDR_BITS = 3
) (
  input  wire logic  clk,
  input  wire logic  rst,
  input  wire logic  rx,
  uart_rx_if.master  bus
);

  localparam int DIV      = SYS_CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam int IDX_W    = $clog2(DATA_BITS + STOP_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
  localparam int DEPTH    = 1 << FIFO_ADDR_BITS;
  localparam int FA       = FIFO_ADDR_BITS;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_rx_meta, r_rx_sync;
  logic [DIV_W-1:0]     r_div_cnt;
  logic                 w_tick;
  logic [3:0]           r_s;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_par_flag, r_frm_flag;
  logic                 r_done, r_done_par, r_done_frm;
  logic                 w_clr_s, w_clr_idx, w_inc_idx, w_shift;
  logic                 w_par_smp, w_stop_smp, w_finish, w_frame_start;
  logic                 w_data_xor, w_par_bad;

  logic [FA:0]          r_wr_ptr, r_rd_ptr;
  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic                 w_empty, w_full, w_push, w_pop;

  // Two-stage synchronizer on the asynchronous line; idles high out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Free-running 16x baud tick; frames never restart it
  assign w_tick = (r_div_cnt == DIV_LAST);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_div_cnt <= '0;
    else      r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
  end

  // Parity check: odd mode wants data^p == 1, even mode wants 0
  assign w_data_xor = (^r_shreg) ^ r_rx_sync;
  assign w_par_bad  = (PARITY_MODE == 2) ? w_data_xor : ~w_data_xor;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM next state and datapath strobes
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_s       = 1'b0;
    w_clr_idx     = 1'b0;
    w_inc_idx     = 1'b0;
    w_shift       = 1'b0;
    w_par_smp     = 1'b0;
    w_stop_smp    = 1'b0;
    w_finish      = 1'b0;
    w_frame_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_sync) begin
          w_state_nxt   = S_START;
          w_clr_s       = 1'b1;
          w_frame_start = 1'b1;
        end
      end
      S_START: begin
        if (w_tick && r_s == 4'd7) begin
          w_clr_s = 1'b1;
          if (r_rx_sync) begin
            w_state_nxt = S_IDLE;       // glitch, not a start bit
          end else begin
            w_state_nxt = S_DATA;
            w_clr_idx   = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (w_tick && r_s == 4'd15) begin
          w_shift = 1'b1;
          if (r_idx == LAST_DATA) begin
            w_state_nxt = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            w_clr_s     = 1'b1;
            w_clr_idx   = 1'b1;
          end else begin
            w_inc_idx = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_tick && r_s == 4'd15) begin
          w_par_smp   = 1'b1;
          w_state_nxt = S_STOP;
          w_clr_s     = 1'b1;
          w_clr_idx   = 1'b1;
        end
      end
      S_STOP: begin
        if (w_tick && r_s == 4'd15) begin
          w_stop_smp = 1'b1;
          if (r_idx == LAST_STOP) begin
            w_finish    = 1'b1;
            w_state_nxt = S_IDLE;
            w_clr_s     = 1'b1;
          end else begin
            w_inc_idx = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sample counters, shift register, error flags and the completion snapshot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s        <= '0;
      r_idx      <= '0;
      r_shreg    <= '0;
      r_par_flag <= 1'b0;
      r_frm_flag <= 1'b0;
      r_done     <= 1'b0;
      r_done_par <= 1'b0;
      r_done_frm <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_clr_s)     r_s <= '0;
      else if (w_tick) r_s <= r_s + 4'd1;
      if (w_clr_idx)      r_idx <= '0;
      else if (w_inc_idx) r_idx <= r_idx + 1'b1;
      if (w_shift) r_shreg <= {r_rx_sync, r_shreg[DATA_BITS-1:1]};
      if (w_frame_start) begin
        r_par_flag <= 1'b0;
        r_frm_flag <= 1'b0;
      end
      if (w_par_smp) r_par_flag <= w_par_bad;
      if (w_stop_smp && !r_rx_sync) r_frm_flag <= 1'b1;
      // Snapshot lets a new frame clear the live flags without racing completion
      if (w_finish) begin
        r_done_par <= r_par_flag;
        r_done_frm <= r_frm_flag | ~r_rx_sync;
      end
    end
  end

  // FIFO status; a read frees a slot in the same cycle a full FIFO is pushed
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[FA] != r_rd_ptr[FA]) &&
                   (r_wr_ptr[FA-1:0] == r_rd_ptr[FA-1:0]);
  assign w_pop   = bus.rd_en & ~w_empty;
  assign w_push  = r_done & ~r_done_frm & (~w_full | bus.rd_en);

  // FIFO pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // FIFO storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[FA-1:0]] <= r_shreg;
  end

  assign bus.rx_data    = r_mem[r_rd_ptr[FA-1:0]];
  assign bus.rx_empty   = w_empty;
  assign bus.parity_err = w_push & r_done_par;
  assign bus.frame_err  = r_done & r_done_frm;
  assign bus.overrun    = r_done & ~r_done_frm & ~w_push;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. Table of frames plus hand
//                sequences for false start, overrun, push-while-reading and
//                reset mid-frame. Bytes expected in the FIFO are kept in a
//                scoreboard queue and compared as they are popped.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  // Fast baud so a full overrun sequence stays short: DIV = 4, 64 clk/bit
  localparam int SYS_CLK_FREQ = 1228800;
  localparam int BAUD_RATE    = 19200;
  localparam int BIT_CLKS     = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx  = 1'b1;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(
    .SYS_CLK_FREQ   (SYS_CLK_FREQ),
    .BAUD_RATE      (BAUD_RATE),
    .DATA_BITS      (8),
    .STOP_BITS      (1),
    .PARITY_MODE    (1),
    .FIFO_ADDR_BITS (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_perr = 0;
  int n_ferr = 0;
  int n_ovr  = 0;
  logic [7:0] exp_q [$];
  bit         seen;
  logic [7:0] got;

  // Pulse counters: a pulse wider than one clock shows up as a count of 2+
  always @(negedge clk) begin
    if (bus.parity_err) n_perr++;
    if (bus.frame_err)  n_ferr++;
    if (bus.overrun)    n_ovr++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; holds the level for n clocks and returns at posedge+1
  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit,
                            input logic sbit, input int stop_len);
    drive(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive(d[i], BIT_CLKS);
    drive(pbit, BIT_CLKS);
    drive(sbit, stop_len);
    drive(1'b1, 2 * BIT_CLKS - stop_len - 48);
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~(^d);
  endfunction

  task automatic pop_check(input string name);
    @(negedge clk);
    check({name, "_nonempty"}, {31'd0, bus.rx_empty}, 32'd0);
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: got data 0x%0h, expected no entry in scoreboard", name, bus.rx_data);
    end else begin
      check(name, {24'd0, bus.rx_data}, {24'd0, exp_q.pop_front()});
    end
    @(posedge clk); #1 bus.rd_en = 1'b1;
    @(posedge clk); #1 bus.rd_en = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par_ok;
    logic       stop;
    bit         push;
    int         perr;
    int         ferr;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int p0, f0, o0;

    vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b1, 0, 0};
    vecs[1] = '{8'h55, 1'b0, 1'b1, 1'b1, 1, 0};
    vecs[2] = '{8'hA3, 1'b1, 1'b0, 1'b0, 0, 1};
    vecs[3] = '{8'h0F, 1'b1, 1'b1, 1'b1, 0, 0};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 0, 0};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1, 0};
    vecs[6] = '{8'h80, 1'b1, 1'b1, 1'b1, 0, 0};
    vecs[7] = '{8'hC6, 1'b0, 1'b0, 1'b0, 0, 1};

    bus.rd_en = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_empty", {31'd0, bus.rx_empty}, 32'd1);
    check("reset_pulses", {29'd0, bus.parity_err, bus.frame_err, bus.overrun}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Table-driven frames
    for (int v = 0; v < 8; v++) begin
      p0 = n_perr; f0 = n_ferr; o0 = n_ovr;
      send_frame(vecs[v].data,
                 vecs[v].par_ok ? odd_par(vecs[v].data) : ~odd_par(vecs[v].data),
                 vecs[v].stop,
                 vecs[v].stop ? BIT_CLKS : 40);
      if (vecs[v].push) exp_q.push_back(vecs[v].data);
      check($sformatf("vec%0d_parity_err", v), n_perr - p0, vecs[v].perr);
      check($sformatf("vec%0d_frame_err", v), n_ferr - f0, vecs[v].ferr);
      check($sformatf("vec%0d_overrun", v), n_ovr - o0, 0);
      if (vecs[v].push) pop_check($sformatf("vec%0d_data", v));
      @(negedge clk);
      check($sformatf("vec%0d_empty_after", v), {31'd0, bus.rx_empty}, 32'd1);
      @(posedge clk); #1;
    end

    // False start: a low glitch well under half a bit
    p0 = n_perr; f0 = n_ferr; o0 = n_ovr;
    drive(1'b0, 14);
    drive(1'b1, 3 * BIT_CLKS);
    @(negedge clk);
    check("false_start_empty", {31'd0, bus.rx_empty}, 32'd1);
    check("false_start_pulses", (n_perr - p0) + (n_ferr - f0) + (n_ovr - o0), 0);
    @(posedge clk); #1;
    send_frame(8'h0F, odd_par(8'h0F), 1'b1, BIT_CLKS);
    exp_q.push_back(8'h0F);
    pop_check("after_false_start");

    // Overrun: nine frames with no reads
    p0 = n_perr; f0 = n_ferr; o0 = n_ovr;
    for (int b = 1; b <= 9; b++) begin
      send_frame(8'(b), odd_par(8'(b)), 1'b1, BIT_CLKS);
      if (b <= 8) exp_q.push_back(8'(b));
      if (b == 8) check("overrun_before_9th", n_ovr - o0, 0);
    end
    check("overrun_count", n_ovr - o0, 1);
    check("overrun_other_pulses", (n_perr - p0) + (n_ferr - f0), 0);
    for (int b = 1; b <= 8; b++) pop_check($sformatf("overrun_read%0d", b));
    @(negedge clk);
    check("overrun_drained", {31'd0, bus.rx_empty}, 32'd1);
    @(posedge clk); #1;

    // Push into an empty FIFO while rd_en is held: push wins, then pops
    o0 = n_ovr;
    exp_q.push_back(8'h3C);
    seen = 1'b0;
    got  = 8'h00;
    bus.rd_en = 1'b1;
    fork
      send_frame(8'h3C, odd_par(8'h3C), 1'b1, BIT_CLKS);
      begin
        for (int c = 0; c < 13 * BIT_CLKS && !seen; c++) begin
          @(negedge clk);
          if (!bus.rx_empty) begin
            seen = 1'b1;
            got  = bus.rx_data;
          end
        end
      end
    join
    bus.rd_en = 1'b0;
    check("rden_push_seen", {31'd0, seen}, 32'd1);
    check("rden_push_data", {24'd0, got}, {24'd0, exp_q.pop_front()});
    @(negedge clk);
    check("rden_push_popped", {31'd0, bus.rx_empty}, 32'd1);
    check("rden_push_overrun", n_ovr - o0, 0);
    @(posedge clk); #1;

    // Reset in the middle of data bit 3 with a byte already queued
    send_frame(8'h5A, odd_par(8'h5A), 1'b1, BIT_CLKS);
    @(negedge clk);
    check("pre_reset_nonempty", {31'd0, bus.rx_empty}, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, BIT_CLKS);
    for (int i = 0; i < 3; i++) drive(1'b1, BIT_CLKS);
    rx = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("reset_midframe_empty", {31'd0, bus.rx_empty}, 32'd1);
    exp_q.delete();
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clk);
    #1;
    send_frame(8'hC6, odd_par(8'hC6), 1'b1, BIT_CLKS);
    exp_q.push_back(8'hC6);
    pop_check("after_reset_data");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
